// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer slice.
package reorder_buffer_pkg;

  localparam int unsigned P_WIDTH   = 31;
  localparam int unsigned P_ROB     = 2;
  localparam int unsigned P_INDEX   = 7;
  localparam int unsigned P_REG     = 4;

  localparam int unsigned TAG_W     = P_ROB + 1;
  localparam int unsigned ROB_DEPTH = 1 << TAG_W;
  localparam int unsigned CNT_W     = TAG_W + 1;

  // controlFlow bit positions on the commit bus
  localparam int unsigned CF_FLUSH  = 0;
  localparam int unsigned CF_TAKEN  = 1;

  // commitInfo bit positions
  typedef enum int unsigned {
    CI_JALR     = 0,
    CI_BRANCH   = 1,
    CI_MEMWRITE = 2,
    CI_REGWRITE = 3
  } commit_info_bit_e;

  typedef struct packed {
    logic               validCommit;
    logic [3:0]         commitInfo;
    logic [P_WIDTH:0]   destCommit;
    logic [P_WIDTH:0]   result;
    logic [P_WIDTH:0]   statusSnap;
    logic [P_INDEX:0]   PHTIndex;
    logic [P_WIDTH:0]   instrPC;
    logic [1:0]         controlFlow;
    logic [P_WIDTH:0]   targetPC;
  } writeCommit;

  typedef struct packed {
    logic               valid;
    logic               ready;
    logic [3:0]         commitInfo;
    logic [P_WIDTH:0]   destination;
    logic [P_INDEX:0]   PHTIndex;
    logic [P_WIDTH:0]   regStatus;
    logic [P_WIDTH:0]   instrPC;
    logic [P_WIDTH:0]   result;
    logic               taken;
    logic               mispredict;
    logic [P_WIDTH:0]   target;
  } rob_entry_t;

endpackage

// File: rtl/rob_entry_array.sv
// Eight-entry ROB storage: allocate port, CDB write port, head read port,
// and a bulk valid-clear used by the misprediction flush.
module rob_entry_array
  import reorder_buffer_pkg::*;
(
  input  logic               clk,
  input  logic               globalReset,
  input  logic               i_alloc_en,
  input  logic [TAG_W-1:0]   i_alloc_tag,
  input  logic [3:0]         i_alloc_info,
  input  logic [P_WIDTH:0]   i_alloc_dest,
  input  logic [P_INDEX:0]   i_alloc_pht,
  input  logic [P_WIDTH:0]   i_alloc_status,
  input  logic [P_WIDTH:0]   i_alloc_pc,
  input  logic               i_cdb_en,
  input  logic [TAG_W-1:0]   i_cdb_tag,
  input  logic [P_WIDTH:0]   i_cdb_result,
  input  logic               i_cdb_taken,
  input  logic               i_cdb_mispredict,
  input  logic [P_WIDTH:0]   i_cdb_target,
  input  logic               i_commit_en,
  input  logic [TAG_W-1:0]   i_head_tag,
  input  logic               i_flush,
  output rob_entry_t         o_head
);

  rob_entry_t r_entry [ROB_DEPTH];

  // Per-entry update; flush dominates so a same-cycle CDB write is lost
  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) r_entry[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        if (i_flush) begin
          r_entry[i].valid <= 1'b0;
        end else begin
          if (i_cdb_en && r_entry[i].valid && (i_cdb_tag == TAG_W'(i))) begin
            r_entry[i].ready      <= 1'b1;
            r_entry[i].result     <= i_cdb_result;
            r_entry[i].taken      <= i_cdb_taken;
            r_entry[i].mispredict <= i_cdb_mispredict;
            r_entry[i].target     <= i_cdb_target;
          end
          if (i_commit_en && (i_head_tag == TAG_W'(i))) begin
            r_entry[i].valid <= 1'b0;
          end
          if (i_alloc_en && (i_alloc_tag == TAG_W'(i))) begin
            r_entry[i].valid       <= 1'b1;
            r_entry[i].ready       <= 1'b0;
            r_entry[i].commitInfo  <= i_alloc_info;
            r_entry[i].destination <= i_alloc_dest;
            r_entry[i].PHTIndex    <= i_alloc_pht;
            r_entry[i].regStatus   <= i_alloc_status;
            r_entry[i].instrPC     <= i_alloc_pc;
            r_entry[i].taken       <= 1'b0;
            r_entry[i].mispredict  <= 1'b0;
          end
        end
      end
    end
  end

  assign o_head = r_entry[i_head_tag];

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at tail, collects CDB results,
// retires the head onto a registered commit bus and flushes on mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = P_WIDTH,
  parameter int unsigned ROB   = P_ROB,
  parameter int unsigned INDEX = P_INDEX,
  parameter int unsigned REG   = P_REG
) (
  input  logic             clk,
  input  logic             globalReset,
  input  logic             robReq,
  input  writeCommit       inputBus,
  input  logic             cdbValid,
  input  logic [ROB:0]     cdbROB,
  input  logic [WIDTH:0]   cdbResult,
  input  logic             cdbTaken,
  input  logic             cdbMispredict,
  input  logic [WIDTH:0]   cdbTarget,
  output logic [ROB:0]     robAllocation,
  output logic             fullRob,
  output logic [ROB:0]     commitROB,
  output writeCommit       robBus
);

  // Field widths come from the package struct, so overrides must agree with it
  if (WIDTH != P_WIDTH || ROB != P_ROB || INDEX != P_INDEX || REG != P_REG) begin : g_bad_params
    $error("reorder_buffer parameters must match reorder_buffer_pkg widths");
  end

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  writeCommit       r_stage;
  rob_entry_t       w_head;
  logic             w_full;
  logic             w_commit;
  logic             w_flush;
  logic             w_alloc;
  logic             w_unused_bus;

  assign w_full   = (r_count == CNT_W'(ROB_DEPTH));
  assign w_commit = w_head.valid & w_head.ready;
  assign w_flush  = w_commit & w_head.mispredict;
  assign w_alloc  = robReq & ~w_full & ~w_flush;

  // Commit-side fields of the request bus are not meaningful on input
  assign w_unused_bus = ^{inputBus.validCommit, inputBus.result,
                          inputBus.controlFlow, inputBus.targetPC};

  rob_entry_array u_array (
    .clk              (clk),
    .globalReset      (globalReset),
    .i_alloc_en       (w_alloc),
    .i_alloc_tag      (r_tail),
    .i_alloc_info     (inputBus.commitInfo),
    .i_alloc_dest     (inputBus.destCommit),
    .i_alloc_pht      (inputBus.PHTIndex),
    .i_alloc_status   (inputBus.statusSnap),
    .i_alloc_pc       (inputBus.instrPC),
    .i_cdb_en         (cdbValid),
    .i_cdb_tag        (cdbROB),
    .i_cdb_result     (cdbResult),
    .i_cdb_taken      (cdbTaken),
    .i_cdb_mispredict (cdbMispredict),
    .i_cdb_target     (cdbTarget),
    .i_commit_en      (w_commit),
    .i_head_tag       (r_head),
    .i_flush          (w_flush),
    .o_head           (w_head)
  );

  // Head/tail pointers and occupancy; flush resets all three
  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc)  r_tail <= r_tail + TAG_W'(1);
      if (w_commit) r_head <= r_head + TAG_W'(1);
      unique case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // First commit stage: snapshot the retiring head entry
  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      r_stage <= '0;
    end else begin
      r_stage.validCommit <= w_commit;
      if (w_commit) begin
        r_stage.commitInfo            <= w_head.commitInfo;
        r_stage.destCommit            <= w_head.destination;
        r_stage.result                <= w_head.result;
        r_stage.statusSnap            <= w_head.regStatus;
        r_stage.PHTIndex              <= w_head.PHTIndex;
        r_stage.instrPC               <= w_head.instrPC;
        r_stage.controlFlow[CF_FLUSH] <= w_head.mispredict;
        r_stage.controlFlow[CF_TAKEN] <= w_head.taken;
        r_stage.targetPC              <= w_head.target;
      end
    end
  end

  // Commit bus: one-cycle valid pulse, payload held between commits
  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      robBus <= '0;
    end else begin
      robBus.validCommit <= r_stage.validCommit;
      if (r_stage.validCommit) robBus <= r_stage;
    end
  end

  assign robAllocation = r_tail;
  assign commitROB     = r_head;
  assign fullRob       = w_full;

endmodule
